// File: rtl/key_pkg.sv
// key_pkg: debounce FSM states and ms-to-cycles helper shared by the key conditioning logic
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_e;

  function automatic int ms_to_cycles(input int freq, input int ms);
    return (freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/key_sync.sv
// key_sync: 2-flop synchronizer with async active-low reset to a chosen idle value
module key_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q, sync_d;

  // shift the raw input one stage per clock
  always_comb sync_d = {sync_q[0], d};

  // synchronizer flops, idle at RST_VAL
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= {2{RST_VAL}};
    else sync_q <= sync_d;

  assign q = sync_q[1];

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer with level, press/release pulses and optional long press (KEY_DEBOUNCE_LONG_PRESS_EN)
module key_debounce
  import key_pkg::*;
#(
  parameter int FREQUENCY     = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_n_clean,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int DB_CYCLES = ms_to_cycles(FREQUENCY, DEBOUNCE_MS);
  localparam int LP_CYCLES = ms_to_cycles(FREQUENCY, LONG_PRESS_MS);
  localparam int DBW       = $clog2(DB_CYCLES + 1);

  if (DB_CYCLES < 1) begin : g_db_err
    $error("key_debounce: DB_CYCLES must be at least 1");
  end

  key_state_e     state_q, state_d;
  logic [DBW-1:0] cnt_q, cnt_d;
  logic           sync;
  logic           pressed_q, pressed_d;
  logic           clean_q, clean_d;
  logic           pp_q, pp_d;
  logic           rp_q, rp_d;

  key_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (key_n),
    .q    (sync)
  );

  // debounce FSM: a level change is accepted once the counter runs out without a bounce
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pp_d    = 1'b0;
    rp_d    = 1'b0;
    unique case (state_q)
      RELEASED: if (!sync) begin
        state_d = PRESS_WAIT;
        cnt_d   = '0;
      end
      PRESS_WAIT: if (sync) begin
        state_d = RELEASED;
        cnt_d   = '0;
      end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
        state_d = PRESSED;
        cnt_d   = '0;
        pp_d    = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      PRESSED: if (sync) begin
        state_d = RELEASE_WAIT;
        cnt_d   = '0;
      end
      RELEASE_WAIT: if (!sync) begin
        state_d = PRESSED;
        cnt_d   = '0;
      end else if (cnt_q == DBW'(DB_CYCLES - 1)) begin
        state_d = RELEASED;
        cnt_d   = '0;
        rp_d    = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    clean_d   = ~pressed_d;
  end

  // FSM, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      clean_q   <= 1'b1;
      pp_q      <= 1'b0;
      rp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      clean_q   <= clean_d;
      pp_q      <= pp_d;
      rp_q      <= rp_d;
    end

  assign key_n_clean   = clean_q;
  assign pressed       = pressed_q;
  assign press_pulse   = pp_q;
  assign release_pulse = rp_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LPW = $clog2(LP_CYCLES + 1);

  if (LP_CYCLES <= DB_CYCLES) begin : g_lp_err
    $error("key_debounce: LP_CYCLES must exceed DB_CYCLES");
  end

  logic [LPW-1:0] hold_q, hold_d;
  logic           lp_q, lp_d;

  // hold timer restarts on each accepted press and survives rejected release bounces
  always_comb begin
    hold_d = pp_d ? '0 : (pressed_q && pressed_d && hold_q != LPW'(LP_CYCLES)) ? hold_q + 1'b1 : hold_q;
    lp_d   = pressed_q && pressed_d && hold_q == LPW'(LP_CYCLES - 1);
  end

  // hold timer and long-press pulse registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      lp_q   <= 1'b0;
    end else begin
      hold_q <= hold_d;
      lp_q   <= lp_d;
    end

  assign long_press = lp_q;
`else
  assign long_press = 1'b0;
`endif

endmodule
